// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared refill-engine types and line-geometry helpers.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } refill_state_t;

  localparam int c_line_words = 4;

  // Byte-offset mask within one line of 32-bit words.
  function automatic logic [31:0] line_offset_mask(input int line_words);
    return 32'(4 * line_words) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : line_addr_gen
// Purpose  : Word-aligned memory address for a line transfer (base + 4*idx).
// Revision : 1.0 - initial release
// ============================================================================
module line_addr_gen
  import dcache_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic [31:0]      wb_base,
  input  logic [31:0]      fill_base,
  input  logic [IDX_W-1:0] idx,
  input  logic             we,
  output logic [31:0]      mem_addr
);

  logic [31:0] w_base;
  logic [31:0] w_offset;

  assign w_base   = we ? wb_base : fill_base;
  assign w_offset = {{(30 - IDX_W){1'b0}}, idx, 2'b00};
  assign mem_addr = w_base + w_offset;

endmodule
`default_nettype wire

// File: rtl/dcache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_refill_ctrl
// Purpose  : D-cache miss engine: optional dirty-victim writeback, then fill.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_refill_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_WORDS = c_line_words,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss_req,
  input  logic [31:0]      miss_addr,
  input  logic             victim_dirty,
  input  logic [31:0]      victim_addr,
  output logic [IDX_W-1:0] vic_idx,
  input  logic [31:0]      vic_data,
  output logic             fill_we,
  output logic [IDX_W-1:0] fill_idx,
  output logic [31:0]      fill_data,
  output logic             fill_done,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      miss_cnt,
  output logic [31:0]      wb_cnt
);

  localparam logic [31:0]      c_off_mask = line_offset_mask(LINE_WORDS);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(LINE_WORDS - 1);

  refill_state_t    r_state;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_fill_base;
  logic [31:0]      r_wb_base;
  logic [31:0]      r_miss_cnt;
  logic [31:0]      r_wb_cnt;

  logic             w_in_wb;
  logic             w_in_fill;
  logic [31:0]      w_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_fill_base <= '0;
      r_wb_base   <= '0;
      r_miss_cnt  <= '0;
      r_wb_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (miss_req) begin
            r_fill_base <= miss_addr & ~c_off_mask;
            r_wb_base   <= victim_addr & ~c_off_mask;
            r_idx       <= '0;
            r_miss_cnt  <= r_miss_cnt + 32'd1;
            r_state     <= victim_dirty ? ST_WB : ST_FILL;
          end
        end
        ST_WB: begin
          if (mem_ack) begin
            if (r_idx == c_last_idx) begin
              r_idx    <= '0;
              r_wb_cnt <= r_wb_cnt + 32'd1;
              r_state  <= ST_FILL;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            // Index wraps to zero on the last word, ready for the next miss.
            r_idx <= r_idx + 1'b1;
            if (r_idx == c_last_idx) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_in_wb   = (r_state == ST_WB);
  assign w_in_fill = (r_state == ST_FILL);

  line_addr_gen #(
    .IDX_W (IDX_W)
  ) u_line_addr_gen (
    .wb_base   (r_wb_base),
    .fill_base (r_fill_base),
    .idx       (r_idx),
    .we        (w_in_wb),
    .mem_addr  (w_addr)
  );

  // Data paths are gated to zero outside their owning state so nothing floats.
  assign busy      = (r_state != ST_IDLE);
  assign mem_req   = w_in_wb | w_in_fill;
  assign mem_we    = w_in_wb;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_in_wb ? vic_data : '0;
  assign vic_idx   = r_idx;
  assign fill_we   = w_in_fill & mem_ack;
  assign fill_idx  = r_idx;
  assign fill_data = w_in_fill ? mem_rdata : '0;
  assign fill_done = (r_state == ST_DONE);
  assign miss_cnt  = r_miss_cnt;
  assign wb_cnt    = r_wb_cnt;

endmodule
`default_nettype wire
